// File: rtl/ft_fifo_responder_if.sv
// FT245-style synchronous FIFO bus plus host-side valid/ready streams.
// The responder uses the slave view; whatever drives the bus uses the master view.
interface ft_fifo_responder_if;
    logic        ft_rd;
    logic        ft_wr;
    logic        ft_oe;
    logic [15:0] ft_data_i;
    logic [1:0]  ft_be_i;
    logic        ft_rxf;
    logic        ft_txe;
    logic [15:0] ft_data_o;
    logic [1:0]  ft_be_o;
    logic        ft_data_oe;
    logic [15:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [17:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic        err_rd_empty;
    logic        err_wr_full;
    logic        err_conflict;

    modport slave (
        input  ft_rd, ft_wr, ft_oe, ft_data_i, ft_be_i,
        input  host_in_data, host_in_valid, host_out_ready,
        output ft_rxf, ft_txe, ft_data_o, ft_be_o, ft_data_oe,
        output host_in_ready, host_out_data, host_out_valid,
        output err_rd_empty, err_wr_full, err_conflict
    );

    modport master (
        output ft_rd, ft_wr, ft_oe, ft_data_i, ft_be_i,
        output host_in_data, host_in_valid, host_out_ready,
        input  ft_rxf, ft_txe, ft_data_o, ft_be_o, ft_data_oe,
        input  host_in_ready, host_out_data, host_out_valid,
        input  err_rd_empty, err_wr_full, err_conflict
    );
endinterface

// File: rtl/ft_fifo_responder.sv
// Chip-side FT600-style 245 FIFO responder: RX FIFO feeds master reads,
// TX FIFO captures master writes; both are first-word-fall-through.
module ft_fifo_responder #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    ft_fifo_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_t;

    state_t          state_reg;
    logic            data_oe_reg;
    logic [15:0]     rx_mem [DEPTH];
    logic [17:0]     tx_mem [DEPTH];
    logic [AW-1:0]   rx_wr_ptr_reg, rx_rd_ptr_reg, tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [CW-1:0]   rx_count_reg, tx_count_reg;
    logic [15:0]     rx_head_reg;
    logic [17:0]     tx_head_reg;
    logic            err_rd_empty_reg, err_wr_full_reg, err_conflict_reg;

    logic            rx_empty, rx_full, tx_empty, tx_full;
    logic            rx_push, rx_pop, tx_push, tx_pop;
    logic            rx_bypass, tx_bypass;
    logic [AW-1:0]   rx_rd_ptr_next, tx_rd_ptr_next;

    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == CW'(DEPTH));
    assign tx_empty = (tx_count_reg == '0);
    assign tx_full  = (tx_count_reg == CW'(DEPTH));

    assign rx_push = !rst && bus.host_in_valid && !rx_full;
    assign rx_pop  = !rst && !bus.ft_oe && !bus.ft_rd && !rx_empty && (state_reg == DRIVE);
    assign tx_push = !rst && !bus.ft_wr && bus.ft_oe && !tx_full;
    assign tx_pop  = !rst && bus.host_out_ready && !tx_empty;

    assign rx_rd_ptr_next = rx_rd_ptr_reg + AW'(rx_pop);
    assign tx_rd_ptr_next = tx_rd_ptr_reg + AW'(tx_pop);

    // A push into a FIFO that will be empty after this edge must reach the head
    // register directly, since the RAM write only lands on this same edge.
    assign rx_bypass = rx_push && (rx_count_reg == CW'(rx_pop));
    assign tx_bypass = tx_push && (tx_count_reg == CW'(tx_pop));

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.host_in_data;
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= {bus.ft_be_i, bus.ft_data_i};
        rx_head_reg <= rx_bypass ? bus.host_in_data : rx_mem[rx_rd_ptr_next];
        tx_head_reg <= tx_bypass ? {bus.ft_be_i, bus.ft_data_i} : tx_mem[tx_rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            data_oe_reg      <= 1'b0;
            rx_wr_ptr_reg    <= '0;
            rx_rd_ptr_reg    <= '0;
            tx_wr_ptr_reg    <= '0;
            tx_rd_ptr_reg    <= '0;
            rx_count_reg     <= '0;
            tx_count_reg     <= '0;
            err_rd_empty_reg <= 1'b0;
            err_wr_full_reg  <= 1'b0;
            err_conflict_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (!bus.ft_oe) state_reg <= TURN;
                TURN: begin
                    if (!bus.ft_oe) begin
                        state_reg   <= DRIVE;
                        data_oe_reg <= 1'b1;
                    end else begin
                        state_reg   <= IDLE;
                    end
                end
                DRIVE: begin
                    if (bus.ft_oe) begin
                        state_reg   <= IDLE;
                        data_oe_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    data_oe_reg <= 1'b0;
                end
            endcase

            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            rx_rd_ptr_reg <= rx_rd_ptr_next;
            tx_rd_ptr_reg <= tx_rd_ptr_next;
            rx_count_reg  <= rx_count_reg + CW'(rx_push) - CW'(rx_pop);
            tx_count_reg  <= tx_count_reg + CW'(tx_push) - CW'(tx_pop);

            if (!bus.ft_rd && !bus.ft_oe && rx_empty && (state_reg == DRIVE))
                err_rd_empty_reg <= 1'b1;
            if (!bus.ft_wr && bus.ft_oe && tx_full)
                err_wr_full_reg <= 1'b1;
            if (!bus.ft_wr && !bus.ft_oe)
                err_conflict_reg <= 1'b1;
        end
    end

    assign bus.ft_rxf         = rx_empty;
    assign bus.ft_txe         = tx_full;
    assign bus.ft_data_o      = rx_head_reg;
    assign bus.ft_be_o        = 2'b11;
    assign bus.ft_data_oe     = data_oe_reg;
    assign bus.host_in_ready  = !rx_full;
    assign bus.host_out_data  = tx_head_reg;
    assign bus.host_out_valid = !tx_empty;
    assign bus.err_rd_empty   = err_rd_empty_reg;
    assign bus.err_wr_full    = err_wr_full_reg;
    assign bus.err_conflict   = err_conflict_reg;
endmodule

// File: tb/tb_ft_fifo_responder.sv
// Directed test-plan steps followed by random traffic, checked every cycle
// against a queue-based model of the two FIFOs and the bus turnaround.
module tb_ft_fifo_responder;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ft_fifo_responder_if bus();

    ft_fifo_responder #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] rx_q[$];
    logic [17:0] tx_q[$];
    int          oe_run;
    bit          m_err_rd, m_err_wf, m_err_cf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus is driven once ft_oe has been sampled low on two consecutive edges.
    task automatic step();
        bit driven, rxp, rxpo, txp, txpo;
        int rs, ts;
        driven = (oe_run >= 2);
        rs = rx_q.size();
        ts = tx_q.size();
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            oe_run = 0;
            m_err_rd = 0;
            m_err_wf = 0;
            m_err_cf = 0;
        end else begin
            rxpo = !bus.ft_oe && !bus.ft_rd && rs > 0 && driven;
            rxp  = bus.host_in_valid && rs < DEPTH;
            txp  = !bus.ft_wr && bus.ft_oe && ts < DEPTH;
            txpo = bus.host_out_ready && ts > 0;
            if (!bus.ft_rd && !bus.ft_oe && rs == 0 && driven) m_err_rd = 1;
            if (!bus.ft_wr && bus.ft_oe && ts == DEPTH) m_err_wf = 1;
            if (!bus.ft_wr && !bus.ft_oe) m_err_cf = 1;
            if (rxpo) void'(rx_q.pop_front());
            if (rxp) rx_q.push_back(bus.host_in_data);
            if (txpo) void'(tx_q.pop_front());
            if (txp) tx_q.push_back({bus.ft_be_i, bus.ft_data_i});
            oe_run = bus.ft_oe ? 0 : ((oe_run >= 2) ? 2 : oe_run + 1);
        end
        @(posedge clk);
        #1;
        check("ft_rxf", bus.ft_rxf, rx_q.size() == 0);
        check("ft_txe", bus.ft_txe, tx_q.size() == DEPTH);
        check("ft_data_oe", bus.ft_data_oe, oe_run >= 2);
        check("ft_be_o", bus.ft_be_o, 2'b11);
        check("host_in_ready", bus.host_in_ready, rx_q.size() < DEPTH);
        check("host_out_valid", bus.host_out_valid, tx_q.size() > 0);
        check("err_rd_empty", bus.err_rd_empty, m_err_rd);
        check("err_wr_full", bus.err_wr_full, m_err_wf);
        check("err_conflict", bus.err_conflict, m_err_cf);
        if (rx_q.size() > 0) check("ft_data_o", bus.ft_data_o, rx_q[0]);
        if (tx_q.size() > 0) check("host_out_data", bus.host_out_data, tx_q[0]);
        $display("cycle: rst=%0b oe=%0b rd=%0b wr=%0b rxq=%0d txq=%0d data_o=%h host_out=%h",
                 rst, bus.ft_oe, bus.ft_rd, bus.ft_wr, rx_q.size(), tx_q.size(),
                 bus.ft_data_o, bus.host_out_data);
    endtask

    initial begin
        oe_run = 0;
        rst = 1'b1;
        bus.ft_rd = 1'b1;
        bus.ft_wr = 1'b1;
        bus.ft_oe = 1'b1;
        bus.ft_data_i = '0;
        bus.ft_be_i = 2'b11;
        bus.host_in_data = '0;
        bus.host_in_valid = 1'b0;
        bus.host_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_rxf", bus.ft_rxf, 1'b1);
        check("reset_txe", bus.ft_txe, 1'b0);
        check("reset_data_oe", bus.ft_data_oe, 1'b0);
        check("reset_in_ready", bus.host_in_ready, 1'b1);
        check("reset_errs", {bus.err_rd_empty, bus.err_wr_full, bus.err_conflict}, 3'b000);

        // Host queues three words, master reads them in one burst.
        bus.host_in_valid = 1'b1;
        bus.host_in_data = 16'h1111; step();
        bus.host_in_data = 16'h2222; step();
        bus.host_in_data = 16'h3333; step();
        bus.host_in_valid = 1'b0;
        bus.ft_oe = 1'b0;
        step();
        check("turn_data_oe", bus.ft_data_oe, 1'b0);
        step();
        check("drive_data_oe", bus.ft_data_oe, 1'b1);
        bus.ft_rd = 1'b0;
        check("burst_word0", bus.ft_data_o, 16'h1111); step();
        check("burst_word1", bus.ft_data_o, 16'h2222); step();
        check("burst_word2", bus.ft_data_o, 16'h3333); step();
        check("burst_rxf_end", bus.ft_rxf, 1'b1);
        check("burst_no_rd_err", bus.err_rd_empty, 1'b0);
        bus.ft_rd = 1'b1;
        bus.ft_oe = 1'b1;
        step();
        check("release_data_oe", bus.ft_data_oe, 1'b0);

        // Master fills the TX FIFO, overflows once, host drains.
        bus.ft_wr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.ft_data_i = 16'(i);
            bus.ft_be_i = (i == DEPTH - 1) ? 2'b01 : 2'b11;
            step();
        end
        check("fill_txe", bus.ft_txe, 1'b1);
        bus.ft_data_i = 16'hDEAD;
        bus.ft_be_i = 2'b11;
        step();
        check("overflow_err", bus.err_wr_full, 1'b1);
        bus.ft_wr = 1'b1;
        bus.host_out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("drain_last", bus.host_out_data, 18'h1000F);
            else check("drain_word", bus.host_out_data, {2'b11, 16'(i)});
            step();
        end
        check("drained_valid", bus.host_out_valid, 1'b0);
        bus.host_out_ready = 1'b0;

        // One-cycle ft_oe pulse: bus never driven, RX word kept.
        bus.host_in_valid = 1'b1;
        bus.host_in_data = 16'hABCD;
        step();
        bus.host_in_valid = 1'b0;
        bus.ft_oe = 1'b0;
        bus.ft_rd = 1'b0;
        step();
        check("pulse_turn_oe", bus.ft_data_oe, 1'b0);
        bus.ft_oe = 1'b1;
        bus.ft_rd = 1'b1;
        step();
        check("pulse_idle_oe", bus.ft_data_oe, 1'b0);
        check("pulse_rx_kept", bus.ft_rxf, 1'b0);
        check("pulse_rx_head", bus.ft_data_o, 16'hABCD);

        // Write while ft_oe is low is a conflict and never queued.
        bus.ft_oe = 1'b0;
        bus.ft_wr = 1'b0;
        step();
        check("conflict_flag", bus.err_conflict, 1'b1);
        check("conflict_no_push", bus.host_out_valid, 1'b0);
        bus.ft_wr = 1'b1;
        bus.ft_oe = 1'b1;
        step();

        // Reset in the middle of a four-word read burst.
        bus.host_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.host_in_data = 16'h5000 + 16'(i);
            step();
        end
        bus.host_in_valid = 1'b0;
        bus.ft_oe = 1'b0;
        step();
        step();
        bus.ft_rd = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_data_oe", bus.ft_data_oe, 1'b0);
        check("midrst_rxf", bus.ft_rxf, 1'b1);
        check("midrst_errs", {bus.err_rd_empty, bus.err_wr_full, bus.err_conflict}, 3'b000);
        rst = 1'b0;
        bus.ft_rd = 1'b1;
        bus.ft_oe = 1'b1;
        step();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) bus.ft_oe = ~bus.ft_oe;
            bus.ft_rd = ($urandom_range(0, 3) == 0);
            bus.ft_wr = bus.ft_oe ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) != 0);
            bus.ft_data_i = 16'($urandom);
            bus.ft_be_i = 2'($urandom);
            bus.host_in_valid = $urandom_range(0, 1) == 1;
            bus.host_in_data = 16'($urandom);
            bus.host_out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
